data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port word-addressed data memory, which performs writes on the falling clock edge and captures reads on the rising edge. Requester 0 (CPU load/store stage) and requester 1 (DMA/loader) each issue a read or write with a level request held until acknowledged. The block grants one requester at a time and drives the memory's address, write-data and read/write strobes for exactly one cycle. It returns read data with an acknowledge and flags illegal addresses without touching memory.

---
 rtl/data_memory_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Grants one of two requesters access to a single-port, word-addressed data
//   memory and sequences each transaction IDLE -> ACCESS -> DONE. The memory
//   commits writes on the falling edge inside ACCESS and captures reads on the
//   rising edge that ends ACCESS, so read data is returned during DONE.
//   Illegal (misaligned or out-of-range) addresses complete with Err and never
//   strobe the memory.
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
//   otherwise port 0 has fixed priority.
//
// Ports
//   Clock, Reset        : system clock, asynchronous active-high reset
//   ReqN/WrN/AddrN/WDataN : level request + command from requester N
//   AckN/ErrN/RDataN    : one-cycle completion, error flag and read data
//   MemAddress, MemWriteData, MemoryRead, MemoryWrite : registered memory side
//   MemReadData         : read data from memory, valid during DONE
//   Busy                : arbiter is not idle
//   Owner               : index of the current/last granted requester
module data_memory_arbiter #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_WORDS = 64
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Req0,
   input  logic             Req1,
   input  logic             Wr0,
   input  logic             Wr1,
   input  logic [WIDTH-1:0] Addr0,
   input  logic [WIDTH-1:0] Addr1,
   input  logic [WIDTH-1:0] WData0,
   input  logic [WIDTH-1:0] WData1,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Err0,
   output logic             Err1,
   output logic [WIDTH-1:0] RData0,
   output logic [WIDTH-1:0] RData1,
   output logic [WIDTH-1:0] MemAddress,
   output logic [WIDTH-1:0] MemWriteData,
   output logic             MemoryRead,
   output logic             MemoryWrite,
   input  logic [WIDTH-1:0] MemReadData,
   output logic             Busy,
   output logic             Owner
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             wr_q, wr_d;
   logic             legal_q, legal_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             err0_q, err0_d;
   logic             err1_q, err1_d;

   logic             any_req;
   logic             grant_sel;
   logic             sel_wr;
   logic [WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0] sel_wdata;
   logic             sel_legal;

   // Word-aligned and word index inside the attached memory.
   function automatic logic is_legal(input logic [WIDTH-1:0] a);
      return (a[1:0] == 2'b00) &&
             ({2'b00, a[WIDTH-1:2]} < WIDTH'(DEPTH_WORDS));
   endfunction

   assign any_req = Req0 | Req1;

   always_comb begin
      grant_sel = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie the port that did not win last time is served.
      if (Req0 && Req1) begin
         grant_sel = ~owner_q;
      end else begin
         grant_sel = Req1;
      end
`else
      grant_sel = ~Req0;
`endif
   end

   assign sel_wr    = grant_sel ? Wr1    : Wr0;
   assign sel_addr  = grant_sel ? Addr1  : Addr0;
   assign sel_wdata = grant_sel ? WData1 : WData0;
   assign sel_legal = is_legal(sel_addr);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      legal_d     = legal_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      err0_d      = 1'b0;
      err1_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ACCESS;
               owner_d = grant_sel;
               wr_d    = sel_wr;
               legal_d = sel_legal;
               // Memory side is loaded here so it is stable for all of ACCESS.
               mem_addr_d  = sel_legal ? sel_addr : '0;
               mem_wdata_d = (sel_legal && sel_wr) ? sel_wdata : '0;
               mem_read_d  = sel_legal & ~sel_wr;
               mem_write_d = sel_legal & sel_wr;
            end
         end
         ACCESS: begin
            state_d     = DONE;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            ack0_d      = ~owner_q;
            ack1_d      = owner_q;
            err0_d      = ~owner_q & ~legal_q;
            err1_d      = owner_q & ~legal_q;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b1;
         wr_q        <= 1'b0;
         legal_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         legal_q     <= legal_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
      end
   end

   assign Ack0         = ack0_q;
   assign Ack1         = ack1_q;
   assign Err0         = err0_q;
   assign Err1         = err1_q;
   // Memory read data is only meaningful during DONE, which is exactly when Ack is high.
   assign RData0       = (ack0_q && legal_q && !wr_q) ? MemReadData : '0;
   assign RData1       = (ack1_q && legal_q && !wr_q) ? MemReadData : '0;
   assign MemAddress   = mem_addr_q;
   assign MemWriteData = mem_wdata_q;
   assign MemoryRead   = mem_read_q;
   assign MemoryWrite  = mem_write_q;
   assign Busy         = (state_q != IDLE);
   assign Owner        = owner_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: directed transactions with expected
// responses queued per port and expected memory accesses queued in order;
// a negedge monitor pops and compares whenever the DUT acks or strobes memory.
module tb_data_memory_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Req0, Req1, Wr0, Wr1;
   logic [31:0] Addr0, Addr1, WData0, WData1;
   logic        Ack0, Ack1, Err0, Err1;
   logic [31:0] RData0, RData1;
   logic [31:0] MemAddress, MemWriteData, MemReadData;
   logic        MemoryRead, MemoryWrite, Busy, Owner;

   always #5 Clock = ~Clock;

   data_memory_arbiter #(
      .WIDTH       (32),
      .DEPTH_WORDS (64)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Req0         (Req0),
      .Req1         (Req1),
      .Wr0          (Wr0),
      .Wr1          (Wr1),
      .Addr0        (Addr0),
      .Addr1        (Addr1),
      .WData0       (WData0),
      .WData1       (WData1),
      .Ack0         (Ack0),
      .Ack1         (Ack1),
      .Err0         (Err0),
      .Err1         (Err1),
      .RData0       (RData0),
      .RData1       (RData1),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemoryRead   (MemoryRead),
      .MemoryWrite  (MemoryWrite),
      .MemReadData  (MemReadData),
      .Busy         (Busy),
      .Owner        (Owner)
   );

   // Memory model: write on falling edge, read captured on rising edge.
   logic [31:0] mem [0:63];
   logic [31:0] mem_rdata;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem_rdata = '0;
   end

   always @(negedge Clock) if (MemoryWrite) mem[MemAddress[7:2]] <= MemWriteData;
   always @(posedge Clock) if (MemoryRead) mem_rdata <= mem[MemAddress[7:2]];
   assign MemReadData = mem_rdata;

   // Scoreboard
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   rsp_t q0[$];
   rsp_t q1[$];
   acc_t mq[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      acc_t a;
      a.wr   = wr;
      a.addr = addr;
      a.data = data;
      mq.push_back(a);
   endtask

   rsp_t mon_r;
   acc_t mon_a;

   always @(negedge Clock) begin
      if (!Reset) begin
         if (MemoryRead || MemoryWrite) begin
            chk("strobe_exclusive", 32'(MemoryRead & MemoryWrite), 32'd0);
            if (mq.size() == 0) begin
               fail("mem_strobe", "memory strobed with no access expected");
            end else begin
               mon_a = mq.pop_front();
               chk("mem_write_strobe", 32'(MemoryWrite), 32'(mon_a.wr));
               chk("mem_address", MemAddress, mon_a.addr);
               if (mon_a.wr) chk("mem_write_data", MemWriteData, mon_a.data);
            end
         end
         if (Ack0) begin
            chk("ack_exclusive", 32'(Ack1), 32'd0);
            if (q0.size() == 0) begin
               fail("ack0", "Ack0 with no transaction expected");
            end else begin
               mon_r = q0.pop_front();
               chk("err0", 32'(Err0), 32'(mon_r.err));
               chk("rdata0", RData0, mon_r.rdata);
               chk("rdata1_idle", RData1, 32'd0);
            end
         end
         if (Ack1) begin
            if (q1.size() == 0) begin
               fail("ack1", "Ack1 with no transaction expected");
            end else begin
               mon_r = q1.pop_front();
               chk("err1", 32'(Err1), 32'(mon_r.err));
               chk("rdata1", RData1, mon_r.rdata);
               chk("rdata0_idle", RData0, 32'd0);
            end
         end
      end
   end

   // Issue one transaction on a port. exp_lat counts rising edges from raising
   // Req until the edge at which the requester samples Ack.
   task automatic xact(input int port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int exp_lat, input int delay, input bit keep);
      rsp_t r;
      int   cnt;
      bit   seen;
      r.err   = err;
      r.rdata = rdata;
      if (port == 0) q0.push_back(r);
      else           q1.push_back(r);
      repeat (delay) @(posedge Clock);
      #1;
      if (port == 0) begin
         Req0 = 1'b1; Wr0 = wr; Addr0 = addr; WData0 = wdata;
      end else begin
         Req1 = 1'b1; Wr1 = wr; Addr1 = addr; WData1 = wdata;
      end
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         @(posedge Clock);
         cnt++;
         @(negedge Clock);
         seen = (port == 0) ? Ack0 : Ack1;
      end
      if (!seen) begin
         fail(port == 0 ? "ack0_timeout" : "ack1_timeout", "no Ack within 40 cycles");
         #1;
      end else begin
         @(posedge Clock);
         cnt++;
         chk(port == 0 ? "latency0" : "latency1", 32'(cnt), 32'(exp_lat));
         #1;
      end
      if (!keep || !seen) begin
         if (port == 0) Req0 = 1'b0;
         else           Req1 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
      Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;

      repeat (2) @(posedge Clock);
      #1;
      chk("rst_ack0", 32'(Ack0), 32'd0);
      chk("rst_ack1", 32'(Ack1), 32'd0);
      chk("rst_err0", 32'(Err0), 32'd0);
      chk("rst_err1", 32'(Err1), 32'd0);
      chk("rst_mem_read", 32'(MemoryRead), 32'd0);
      chk("rst_mem_write", 32'(MemoryWrite), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_mem_address", MemAddress, 32'd0);
      chk("rst_mem_wdata", MemWriteData, 32'd0);
      chk("rst_rdata0", RData0, 32'd0);
      chk("rst_rdata1", RData1, 32'd0);
      chk("rst_owner", 32'(Owner), 32'd1);
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      chk("idle_busy", 32'(Busy), 32'd0);

      // Port 0 write then read-back.
      exp_mem(1'b1, 32'h10, 32'hDEADBEEF);
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 3, 0, 1'b0);
      exp_mem(1'b0, 32'h10, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, 1'b0);
      chk("owner_after_p0", 32'(Owner), 32'd0);

      // Port 1 at the last legal word.
      exp_mem(1'b1, 32'hFC, 32'h0BADC0DE);
      xact(1, 1'b1, 32'hFC, 32'h0BADC0DE, 1'b0, 32'h0, 3, 0, 1'b0);
      exp_mem(1'b0, 32'hFC, 32'h0);
      xact(1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0BADC0DE, 3, 0, 1'b0);
      chk("owner_after_p1", 32'(Owner), 32'd1);

      // Illegal addresses: out of range, misaligned read, misaligned write.
      xact(1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 3, 0, 1'b0);
      xact(1, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 3, 0, 1'b0);
      xact(0, 1'b1, 32'h2, 32'h12345678, 1'b1, 32'h0, 3, 0, 1'b0);
      chk("illegal_write_untouched", mem[0], 32'd0);

      // Preload words used below.
      exp_mem(1'b1, 32'h14, 32'hCAFEF00D);
      xact(0, 1'b1, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0, 3, 0, 1'b0);
      exp_mem(1'b1, 32'h20, 32'h11112222);
      xact(1, 1'b1, 32'h20, 32'h11112222, 1'b0, 32'h0, 3, 0, 1'b0);
      exp_mem(1'b1, 32'h24, 32'h13572468);
      xact(1, 1'b1, 32'h24, 32'h13572468, 1'b0, 32'h0, 3, 0, 1'b0);

      // Port 1 raises Req while port 0 is in ACCESS.
      exp_mem(1'b0, 32'h14, 32'h0);
      exp_mem(1'b0, 32'h20, 32'h0);
      @(posedge Clock);
      fork
         xact(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 3, 0, 1'b0);
         xact(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 5, 1, 1'b0);
      join
      chk("owner_after_contention", 32'(Owner), 32'd1);

      // Both ports hold Req high for two reads each.
`ifdef ARB_ROUND_ROBIN_EN
      exp_mem(1'b0, 32'h10, 32'h0);
      exp_mem(1'b0, 32'h20, 32'h0);
      exp_mem(1'b0, 32'h14, 32'h0);
      exp_mem(1'b0, 32'h24, 32'h0);
      @(posedge Clock);
      fork
         begin
            xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, 1'b1);
            xact(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 6, 0, 1'b0);
         end
         begin
            xact(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 6, 0, 1'b1);
            xact(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h13572468, 6, 0, 1'b0);
         end
      join
`else
      exp_mem(1'b0, 32'h10, 32'h0);
      exp_mem(1'b0, 32'h14, 32'h0);
      exp_mem(1'b0, 32'h20, 32'h0);
      exp_mem(1'b0, 32'h24, 32'h0);
      @(posedge Clock);
      fork
         begin
            xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, 1'b1);
            xact(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 3, 0, 1'b0);
         end
         begin
            xact(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 9, 0, 1'b1);
            xact(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h13572468, 3, 0, 1'b0);
         end
      join
`endif

      // Reset in the middle of a write's ACCESS cycle, before the falling edge.
      @(posedge Clock);
      #1;
      Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 32'h30; WData0 = 32'h00000055;
      @(posedge Clock);
      #1;
      chk("access_busy", 32'(Busy), 32'd1);
      chk("access_mem_write", 32'(MemoryWrite), 32'd1);
      chk("access_mem_address", MemAddress, 32'h30);
      #1;
      Reset = 1'b1;
      #1;
      chk("rst_mid_mem_write", 32'(MemoryWrite), 32'd0);
      chk("rst_mid_busy", 32'(Busy), 32'd0);
      chk("rst_mid_mem_address", MemAddress, 32'd0);
      chk("rst_mid_owner", 32'(Owner), 32'd1);
      Req0 = 1'b0; Wr0 = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      repeat (3) @(posedge Clock);
      chk("rst_write_suppressed", mem[12], 32'd0);

      // First tie after reset goes to port 0.
      exp_mem(1'b0, 32'h10, 32'h0);
      exp_mem(1'b0, 32'h24, 32'h0);
      @(posedge Clock);
      fork
         xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, 1'b0);
         xact(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h13572468, 6, 0, 1'b0);
      join
      chk("owner_after_tie", 32'(Owner), 32'd1);

      repeat (3) @(posedge Clock);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("mem_q_drained", 32'(mq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
